// File: rtl/micro_sequencer_if.sv
// ---------------------------------------------------------------------------
// micro_sequencer_if : opcode/condition bus into the sequencer, address+flags out
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface micro_sequencer_if;
  logic       stall;
  logic [2:0] inst;
  logic       cc;
  logic [7:0] d;
  logic [7:0] y;
  logic       cnt_z;
  logic       stk_full;
  logic       stk_empty;
  logic       stk_err;

  modport master (
    output stall, inst, cc, d,
    input  y, cnt_z, stk_full, stk_empty, stk_err
  );

  modport slave (
    input  stall, inst, cc, d,
    output y, cnt_z, stk_full, stk_empty, stk_err
  );
endinterface

`default_nettype wire

// File: rtl/micro_sequencer.sv
// ---------------------------------------------------------------------------
// micro_sequencer : 8-bit micro-address sequencer, 4-deep call stack, loop counter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module micro_sequencer (
  input  logic             cp,
  input  logic             rst_lo,
  micro_sequencer_if.slave bus
);

  localparam logic [2:0] OP_JZ   = 3'd0;
  localparam logic [2:0] OP_CONT = 3'd1;
  localparam logic [2:0] OP_CJP  = 3'd2;
  localparam logic [2:0] OP_CJS  = 3'd3;
  localparam logic [2:0] OP_CRTN = 3'd4;
  localparam logic [2:0] OP_LDCT = 3'd5;
  localparam logic [2:0] OP_RPCT = 3'd6;
  localparam logic [2:0] OP_LOOP = 3'd7;

  localparam logic [2:0] C_SP_FULL = 3'd4;

  logic [7:0] r_upc;
  logic [7:0] r_cnt;
  logic [7:0] r_stk [0:3];
  logic [2:0] r_sp;
  logic       r_err;

  logic [7:0] w_inc;
  logic [7:0] w_tos;
  logic [1:0] w_tos_idx;
  logic       w_full;
  logic       w_empty;

  logic [7:0] w_upc_nxt;
  logic [7:0] w_cnt_nxt;
  logic [2:0] w_sp_nxt;
  logic       w_err_nxt;
  logic       w_push;

  assign w_inc     = r_upc + 8'd1;
  assign w_full    = (r_sp == C_SP_FULL);
  assign w_empty   = (r_sp == 3'd0);
  // sp of 4 maps to slot 3 through the 2-bit wrap; sp of 0 is never read
  assign w_tos_idx = r_sp[1:0] - 2'd1;
  assign w_tos     = r_stk[w_tos_idx];

  always_comb begin
    w_upc_nxt = w_inc;
    w_cnt_nxt = r_cnt;
    w_sp_nxt  = r_sp;
    w_err_nxt = r_err;
    w_push    = 1'b0;
    case (bus.inst)
      OP_JZ: begin
        w_upc_nxt = 8'd0;
        w_sp_nxt  = 3'd0;
      end
      OP_CONT: ;
      OP_CJP: begin
        if (bus.cc) w_upc_nxt = bus.d;
      end
      OP_CJS: begin
        if (bus.cc) begin
          w_upc_nxt = bus.d;
          if (w_full) begin
            w_err_nxt = 1'b1;
          end else begin
            w_push   = 1'b1;
            w_sp_nxt = r_sp + 3'd1;
          end
        end
      end
      OP_CRTN: begin
        if (bus.cc) begin
          if (w_empty) begin
            w_err_nxt = 1'b1;
          end else begin
            w_upc_nxt = w_tos;
            w_sp_nxt  = r_sp - 3'd1;
          end
        end
      end
      OP_LDCT: begin
        w_cnt_nxt = bus.d;
      end
      OP_RPCT: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nxt = r_cnt - 8'd1;
          w_upc_nxt = bus.d;
        end
      end
      OP_LOOP: begin
        // empty stack flags an error whatever the condition says
        if (w_empty) begin
          w_err_nxt = 1'b1;
        end else if (bus.cc) begin
          w_sp_nxt = r_sp - 3'd1;
        end else begin
          w_upc_nxt = w_tos;
        end
      end
      default: ;
    endcase
  end

  // Stack slots are intentionally left out of the reset branch: only sp clears
  always_ff @(posedge cp or negedge rst_lo) begin
    if (!rst_lo) begin
      r_upc <= 8'd0;
      r_cnt <= 8'd0;
      r_sp  <= 3'd0;
      r_err <= 1'b0;
    end else if (!bus.stall) begin
      r_upc <= w_upc_nxt;
      r_cnt <= w_cnt_nxt;
      r_sp  <= w_sp_nxt;
      r_err <= w_err_nxt;
      if (w_push) r_stk[r_sp[1:0]] <= w_inc;
    end
  end

  assign bus.y         = r_upc;
  assign bus.cnt_z     = (r_cnt == 8'd0);
  assign bus.stk_full  = w_full;
  assign bus.stk_empty = w_empty;
  assign bus.stk_err   = r_err;

endmodule

`default_nettype wire
